// File: rtl/ack_bus_pkg.sv
// Shared definitions for the ACK bus: source IDs, requester FSM states and
// default sizing for the per-source requester.
package ack_bus_pkg;

  localparam logic [1:0] ID_MEM  = 2'b00;
  localparam logic [1:0] ID_SHA  = 2'b01;
  localparam logic [1:0] ID_AES  = 2'b10;
  localparam logic [1:0] ID_CTRL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    GAP  = 2'b10
  } ack_state_e;

  localparam int PEND_W_DEF     = 3;
  localparam int STARVE_MAX_DEF = 16;

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter. Simultaneous inc and dec cancel out. An
// increment at full scale or a decrement at zero is dropped and reported
// through ovf/unf in the same cycle so the parent can record it.
module sat_updown_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         ovf,
  output logic         unf
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // Next-count computation with saturation at both ends
  always_comb begin
    count_next = count;
    ovf        = 1'b0;
    unf        = 1'b0;
    if (inc && !dec) begin
      if (count == CNT_MAX) ovf = 1'b1;
      else                  count_next = count + 1'b1;
    end else if (dec && !inc) begin
      if (count == '0) unf = 1'b1;
      else             count_next = count - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count_next;
  end

endmodule

// File: rtl/ack_req_client.sv
// Per-source ACK requester. Counts host completions, requests the arbiter,
// retires one pending ACK per accepted grant and inserts a one-cycle release
// gap after every grant so lower-priority sources get a chance to win.
// Also reports starvation, counter overflow and arbiter protocol errors.
module ack_req_client
  import ack_bus_pkg::*;
#(
  parameter logic [1:0] SRC_ID     = ID_MEM,
  parameter int         PEND_W     = PEND_W_DEF,
  parameter int         STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_i,
  output logic              req_o,
  input  logic              ack_ready_i,
  input  logic              ack_event_i,
  input  logic [1:0]        winner_id_i,
  output logic [PEND_W-1:0] pending_o,
  output logic              busy_o,
  output logic              starve_o,
  output logic              ovf_o,
  output logic              perr_o,
  input  logic              clr_err_i
);

  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  ack_state_e        state;
  ack_state_e        state_next;
  logic [SW-1:0]     starve_cnt;
  logic [PEND_W-1:0] pending_next;
  logic              grant;
  logic              pend_ovf;
  logic              pend_unf;
  logic              perr_set;

  // req_o decodes the state register directly, so an async reset drops it
  // at once without waiting for an edge.
  assign req_o  = (state == REQ);
  assign grant  = req_o & ack_ready_i & ack_event_i & (winner_id_i == SRC_ID);
  assign busy_o = (pending_o != '0);

  sat_updown_cnt #(.W(PEND_W)) u_pend (
    .clk       (clk),
    .rst       (rst),
    .inc       (done_i),
    .dec       (grant),
    .count     (pending_o),
    .count_next(pending_next),
    .ovf       (pend_ovf),
    .unf       (pend_unf)
  );

  // A grant with nothing pending cannot happen with a well-behaved arbiter;
  // the done_i term covers the case where inc and dec cancel at zero.
  assign perr_set = (ack_ready_i & ~req_o)
                  | (ack_ready_i & (winner_id_i != SRC_ID))
                  | (ack_ready_i & ~ack_event_i)
                  | pend_unf
                  | (grant & done_i & ~busy_o);

  // Next-state logic: IDLE -> REQ -> GAP -> (REQ | IDLE)
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (busy_o || done_i) state_next = REQ;
      REQ:     if (grant) state_next = GAP;
      GAP:     state_next = (pending_next != '0) ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Starvation counter: counts ungranted REQ cycles, saturating at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if ((state != REQ) || grant) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign starve_o = (starve_cnt >= STARVE_LIM);

  // Sticky error flags; a new error on the clearing edge takes precedence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_o  <= 1'b0;
      perr_o <= 1'b0;
    end else begin
      if (pend_ovf)       ovf_o <= 1'b1;
      else if (clr_err_i) ovf_o <= 1'b0;
      if (perr_set)       perr_o <= 1'b1;
      else if (clr_err_i) perr_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ack_req_client.sv
// Scoreboard bench for ack_req_client. Four instances: a SHA and an AES
// client sharing a small lowest-ID-wins arbiter model, a client with a short
// starvation limit and a client with a 2-bit pending counter.
module tb_ack_req_client;
  import ack_bus_pkg::*;

  localparam int T_REQ_A = 0, T_PEND_A = 1, T_BUSY_A = 2, T_STARVE_A = 3,
                 T_OVF_A = 4, T_PERR_A = 5, T_REQ_B = 6, T_BUSY_B = 7,
                 T_STARVE_B = 8, T_PERR_B = 9, T_REQ_S = 10, T_STARVE_S = 11,
                 T_PERR_S = 12, T_PEND_P = 13, T_OVF_P = 14;

  typedef struct {
    int    tag;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       arb_en, man_ready, man_event;
  logic [1:0] man_winner;
  logic       done_a, clr_a, done_b, done_s, rdy_s, done_p, clr_p;

  logic       req_a, busy_a, starve_a, ovf_a, perr_a;
  logic [2:0] pend_a;
  logic       req_b, busy_b, starve_b, ovf_b, perr_b;
  logic [2:0] pend_b;
  logic       req_s, busy_s, starve_s, ovf_s, perr_s;
  logic [2:0] pend_s;
  logic       req_p, busy_p, starve_p, ovf_p, perr_p;
  logic [1:0] pend_p;

  logic       arb_evt;
  logic [1:0] arb_win;
  logic       ready_a, event_a, ready_b, event_b;
  logic [1:0] winner_a, winner_b;

  always #5 clk = ~clk;

  // Lowest source ID wins; grants are combinational on the requests
  always_comb begin
    arb_evt  = req_a | req_b;
    arb_win  = req_a ? ID_SHA : (req_b ? ID_AES : ID_MEM);
    ready_a  = arb_en ? (req_a && arb_win == ID_SHA) : man_ready;
    event_a  = arb_en ? arb_evt : man_event;
    winner_a = arb_en ? arb_win : man_winner;
    ready_b  = arb_en ? (req_b && arb_win == ID_AES) : 1'b0;
    event_b  = arb_en ? arb_evt : 1'b0;
    winner_b = arb_en ? arb_win : 2'b00;
  end

  ack_req_client #(.SRC_ID(ID_SHA)) u_a (
    .clk(clk), .rst(rst), .done_i(done_a), .req_o(req_a),
    .ack_ready_i(ready_a), .ack_event_i(event_a), .winner_id_i(winner_a),
    .pending_o(pend_a), .busy_o(busy_a), .starve_o(starve_a),
    .ovf_o(ovf_a), .perr_o(perr_a), .clr_err_i(clr_a));

  ack_req_client #(.SRC_ID(ID_AES)) u_b (
    .clk(clk), .rst(rst), .done_i(done_b), .req_o(req_b),
    .ack_ready_i(ready_b), .ack_event_i(event_b), .winner_id_i(winner_b),
    .pending_o(pend_b), .busy_o(busy_b), .starve_o(starve_b),
    .ovf_o(ovf_b), .perr_o(perr_b), .clr_err_i(1'b0));

  ack_req_client #(.SRC_ID(ID_MEM), .STARVE_MAX(4)) u_s (
    .clk(clk), .rst(rst), .done_i(done_s), .req_o(req_s),
    .ack_ready_i(rdy_s), .ack_event_i(rdy_s), .winner_id_i(ID_MEM),
    .pending_o(pend_s), .busy_o(busy_s), .starve_o(starve_s),
    .ovf_o(ovf_s), .perr_o(perr_s), .clr_err_i(1'b0));

  ack_req_client #(.SRC_ID(ID_MEM), .PEND_W(2)) u_p (
    .clk(clk), .rst(rst), .done_i(done_p), .req_o(req_p),
    .ack_ready_i(1'b0), .ack_event_i(1'b0), .winner_id_i(ID_MEM),
    .pending_o(pend_p), .busy_o(busy_p), .starve_o(starve_p),
    .ovf_o(ovf_p), .perr_o(perr_p), .clr_err_i(clr_p));

  function automatic int observe(input int tag);
    case (tag)
      T_REQ_A:    return int'(req_a);
      T_PEND_A:   return int'(pend_a);
      T_BUSY_A:   return int'(busy_a);
      T_STARVE_A: return int'(starve_a);
      T_OVF_A:    return int'(ovf_a);
      T_PERR_A:   return int'(perr_a);
      T_REQ_B:    return int'(req_b);
      T_BUSY_B:   return int'(busy_b);
      T_STARVE_B: return int'(starve_b);
      T_PERR_B:   return int'(perr_b);
      T_REQ_S:    return int'(req_s);
      T_STARVE_S: return int'(starve_s);
      T_PERR_S:   return int'(perr_s);
      T_PEND_P:   return int'(pend_p);
      T_OVF_P:    return int'(ovf_p);
      default:    return -1;
    endcase
  endfunction

  task automatic expect_val(input int tag, input int exp, input string name);
    exp_t e;
    e.tag  = tag;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: drains the scoreboard on every falling edge
  always @(negedge clk) begin : mon
    exp_t e;
    int   got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = observe(e.tag);
      n_cmp++;
      if (got != e.exp) begin
        n_bad++;
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", e.name, got, e.exp, $time);
      end
    end
  end

  int dpat[7] = '{1, 1, 1, 0, 0, 0, 0};
  int rpat[7] = '{0, 1, 0, 1, 0, 1, 0};
  int ppat[7] = '{0, 1, 1, 2, 1, 1, 0};

  initial begin
    rst = 1'b1; arb_en = 1'b0; man_ready = 1'b0; man_event = 1'b0;
    man_winner = 2'b00; done_a = 1'b0; clr_a = 1'b0; done_b = 1'b0;
    done_s = 1'b0; rdy_s = 1'b0; done_p = 1'b0; clr_p = 1'b0;

    // reset state
    tick(); tick();
    expect_val(T_REQ_A, 0, "rst_req");
    expect_val(T_PEND_A, 0, "rst_pend");
    expect_val(T_BUSY_A, 0, "rst_busy");
    expect_val(T_STARVE_A, 0, "rst_starve");
    expect_val(T_OVF_A, 0, "rst_ovf");
    expect_val(T_PERR_A, 0, "rst_perr");
    tick();
    rst = 1'b0;

    // single completion, granted in the first REQ cycle
    done_a = 1'b1;
    expect_val(T_REQ_A, 0, "s1_req_t0");
    tick();
    done_a = 1'b0;
    expect_val(T_REQ_A, 1, "s1_req_t1");
    expect_val(T_PEND_A, 1, "s1_pend_t1");
    expect_val(T_BUSY_A, 1, "s1_busy_t1");
    man_ready = 1'b1; man_event = 1'b1; man_winner = ID_SHA;
    tick();
    man_ready = 1'b0; man_event = 1'b0; man_winner = 2'b00;
    expect_val(T_REQ_A, 0, "s1_req_t2");
    expect_val(T_PEND_A, 0, "s1_pend_t2");
    expect_val(T_BUSY_A, 0, "s1_busy_t2");
    tick();
    expect_val(T_REQ_A, 0, "s1_req_t3");
    expect_val(T_PERR_A, 0, "s1_perr_t3");
    tick();

    // three back-to-back completions with an always-granting arbiter
    arb_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      done_a = dpat[i][0];
      expect_val(T_REQ_A, rpat[i], $sformatf("b2b_req_%0d", i));
      expect_val(T_PEND_A, ppat[i], $sformatf("b2b_pend_%0d", i));
      tick();
    end
    done_a = 1'b0;
    tick();

    // SHA and AES request together; AES wins during SHA's gap
    done_a = 1'b1; done_b = 1'b1;
    tick();
    done_a = 1'b0; done_b = 1'b0;
    expect_val(T_REQ_A, 1, "arb_req_a_d1");
    expect_val(T_REQ_B, 1, "arb_req_b_d1");
    tick();
    expect_val(T_REQ_A, 0, "arb_req_a_d2");
    expect_val(T_REQ_B, 1, "arb_req_b_d2");
    expect_val(T_BUSY_B, 1, "arb_busy_b_d2");
    expect_val(T_STARVE_B, 0, "arb_starve_b_d2");
    tick();
    expect_val(T_REQ_B, 0, "arb_req_b_d3");
    expect_val(T_BUSY_B, 0, "arb_busy_b_d3");
    expect_val(T_STARVE_A, 0, "arb_starve_a_d3");
    expect_val(T_PERR_A, 0, "arb_perr_a_d3");
    expect_val(T_PERR_B, 0, "arb_perr_b_d3");
    tick();
    arb_en = 1'b0;

    // starvation with a limit of 4
    done_s = 1'b1;
    tick();
    done_s = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expect_val(T_REQ_S, 1, $sformatf("stv_req_%0d", i));
      expect_val(T_STARVE_S, 0, $sformatf("stv_flag_%0d", i));
      tick();
    end
    expect_val(T_STARVE_S, 1, "stv_flag_5");
    rdy_s = 1'b1;
    tick();
    rdy_s = 1'b0;
    expect_val(T_STARVE_S, 0, "stv_after_grant");
    expect_val(T_REQ_S, 0, "stv_gap_req");
    expect_val(T_PERR_S, 0, "stv_perr");
    tick();

    // 2-bit pending counter overflow and error clear
    for (int i = 0; i < 4; i++) begin
      done_p = 1'b1;
      expect_val(T_PEND_P, i, $sformatf("ovf_pend_%0d", i));
      expect_val(T_OVF_P, 0, $sformatf("ovf_flag_%0d", i));
      tick();
    end
    done_p = 1'b0;
    expect_val(T_PEND_P, 3, "ovf_pend_sat");
    expect_val(T_OVF_P, 1, "ovf_flag_set");
    clr_p = 1'b1;
    tick();
    clr_p = 1'b0;
    expect_val(T_OVF_P, 0, "ovf_flag_clr");
    expect_val(T_PEND_P, 3, "ovf_pend_kept");
    tick();

    // grant carrying the wrong winner ID
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    expect_val(T_PERR_A, 0, "perr_before");
    man_ready = 1'b1; man_event = 1'b1; man_winner = ID_SHA ^ 2'b01;
    tick();
    man_ready = 1'b0; man_event = 1'b0; man_winner = 2'b00;
    expect_val(T_PERR_A, 1, "perr_set");
    expect_val(T_PEND_A, 1, "perr_pend");
    expect_val(T_REQ_A, 1, "perr_req");
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    expect_val(T_PERR_A, 0, "perr_clr");
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    expect_val(T_PEND_A, 2, "mid_pend");
    expect_val(T_REQ_A, 1, "mid_req");
    tick();

    // asynchronous reset in the middle of a request
    rst = 1'b1;
    expect_val(T_REQ_A, 0, "arst_req");
    expect_val(T_PEND_A, 0, "arst_pend");
    expect_val(T_BUSY_A, 0, "arst_busy");
    expect_val(T_PERR_A, 0, "arst_perr");
    expect_val(T_OVF_A, 0, "arst_ovf");
    expect_val(T_STARVE_A, 0, "arst_starve");
    expect_val(T_PEND_P, 0, "arst_pend_p");
    tick();
    rst = 1'b0;
    tick();
    tick();

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
